nibble_scanner: RTL and testbench
=================================

NIBBLE_SCANNER -- requirements
Module: nibble_scanner

Interface
REQ-001 Parameter: DWELL, default 1, minimum cycles each select value is held before it may advance (legal range 1..16).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to capture din and begin a scan; sampled only in IDLE.
REQ-005 din  input  32  word to scan; eight 4-bit nibbles, nibble k = din[4k+3:4k].
REQ-006 ready  input  1  downstream accepts the currently selected nibble this cycle.
REQ-007 w  output  32  captured word, driven to the downstream 8:1 nibble mux data input.
REQ-008 s  output  3  nibble select, driven to the downstream mux select input.
REQ-009 valid  output  1  high while w/s present a nibble to be consumed.
REQ-010 busy  output  1  high in SCAN and DONE states.
REQ-011 done  output  1  one-cycle pulse after the last nibble is accepted.

Function
REQ-012 FSM states SHALL be IDLE, SCAN and DONE.
REQ-013 In IDLE with start=1, the block SHALL capture din into w, load s with the first index and enter SCAN on the same edge.
REQ-014 valid SHALL be high exactly in SCAN; busy SHALL be high in SCAN and DONE.
REQ-015 A 4-bit dwell counter SHALL clear on entry to SCAN and on every select advance, and SHALL increment each SCAN cycle, saturating at DWELL-1.
REQ-016 An advance SHALL occur on a SCAN edge where ready=1 and the dwell count equals DWELL-1.
REQ-017 With ready=0, s, w and the dwell count (once saturated) SHALL hold indefinitely.
REQ-018 An advance at a non-last index SHALL step s by one; an advance at the last index SHALL enter DONE, with valid low from that edge.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-020 start SHALL be ignored in SCAN and DONE; start in the IDLE cycle following DONE SHALL begin a new scan.
REQ-021 w SHALL change only on capture, and s SHALL change only on capture or advance.
REQ-022 With DWELL=1, one nibble per cycle SHALL be consumed under continuous ready, i.e. 8 cycles from capture to DONE.

Reset
REQ-023 On assertion of rst, the block SHALL immediately enter IDLE with w=0, s=0, valid=0, busy=0, done=0 and the dwell count at 0.
REQ-024 Reset asserted mid-scan SHALL abort the scan without a done pulse.
REQ-025 After rst deasserts, the block SHALL respond to start on the first rising edge.

Configuration
REQ-026 Macro NIBBLE_SCAN_DOWN_EN: when defined, the first index SHALL be 7, s SHALL decrement on each advance, and the last index SHALL be 0.
REQ-027 When NIBBLE_SCAN_DOWN_EN is undefined, the first index SHALL be 0, s SHALL increment on each advance, and the last index SHALL be 7.
REQ-028 Reset value of s SHALL be 0 in both builds.

Structure
REQ-029 A shared package SHALL hold the state encoding (IDLE=2'b00, SCAN=2'b01, DONE=2'b10) and the constants NIBBLES=8 and SEL_W=3.
REQ-030 The select sequencing SHALL be a sub-module named sel_counter_mod8, a 3-bit counter with load, enable and direction inputs, and a terminal-count output.
REQ-031 All FSM state updates SHALL be registered; outputs SHALL be decoded from state or taken from registers, with no combinational path from ready or start to any output.

Verification
REQ-032 Reset: rst=1 mid-scan at s=3 -> all outputs 0 immediately; no done pulse; next start is accepted.
REQ-033 Basic scan: DWELL=1, ready=1, start with din=32'h8765_4321 -> s=0..7 on consecutive cycles, w held, done pulses once on cycle 9, then IDLE.
REQ-034 Backpressure: ready=0 for 5 cycles at s=2 -> s holds at 2 with valid=1; s advances to 3 on the first ready=1 edge.
REQ-035 Dwell: DWELL=4, ready=1 -> each s value held 4 cycles; total 32 SCAN cycles before done.
REQ-036 Start ignored: din=32'hFFFF_FFFF with start pulsed while busy -> w unchanged; back-to-back start in the IDLE cycle after DONE captures the new word.
REQ-037 NIBBLE_SCAN_DOWN_EN build: same stimulus as REQ-033 -> s sequence 7..0, done after s=0 is accepted.

Source files
------------

// File: rtl/nibble_scanner_pkg.sv
// Shared encoding and constants for the nibble scanner.
// NIBBLE_SCAN_DOWN_EN selects a descending scan (7..0) instead of 0..7.
package nibble_scanner_pkg;

    localparam int NIBBLES = 8;
    localparam int SEL_W   = 3;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_SCAN = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

`ifdef NIBBLE_SCAN_DOWN_EN
    localparam logic [SEL_W-1:0] FIRST_SEL = 3'd7;
    localparam logic             SCAN_DOWN = 1'b1;
`else
    localparam logic [SEL_W-1:0] FIRST_SEL = 3'd0;
    localparam logic             SCAN_DOWN = 1'b0;
`endif

endpackage

// File: rtl/nibble_scanner_sel_counter_mod8.sv
// Mod-8 select counter with load, enable and direction; tc flags the last
// index for the current direction.
module sel_counter_mod8
    import nibble_scanner_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [SEL_W-1:0] load_val,
    input  logic             en,
    input  logic             down,
    output logic [SEL_W-1:0] cnt,
    output logic             tc
);

    logic [SEL_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (en)
            cnt_d = down ? (cnt_q - 1'b1) : (cnt_q + 1'b1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
    assign tc  = down ? (cnt_q == '0) : (cnt_q == '1);

endmodule

// File: rtl/nibble_scanner.sv
// Captures a 32-bit word and walks a nibble select across it, honouring a
// minimum dwell per select and downstream backpressure. NIBBLE_SCAN_DOWN_EN reverses order.
module nibble_scanner
    import nibble_scanner_pkg::*;
#(
    parameter int DWELL = 1
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] din,
    input  logic                 ready,
    output logic [4*NIBBLES-1:0] w,
    output logic [SEL_W-1:0]     s,
    output logic                 valid,
    output logic                 busy,
    output logic                 done
);

    localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

    logic [1:0]           state_q, state_d;
    logic [4*NIBBLES-1:0] w_q, w_d;
    logic [3:0]           dwell_q, dwell_d;
    logic                 capture, advance, last_sel;

    always_comb begin
        capture = (state_q == ST_IDLE) && start;
        advance = (state_q == ST_SCAN) && ready && (dwell_q == DWELL_LAST);

        state_d = state_q;
        w_d     = w_q;
        dwell_d = dwell_q;

        case (state_q)
            ST_IDLE: if (capture) state_d = ST_SCAN;
            ST_SCAN: if (advance && last_sel) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (capture)
            w_d = din;

        // Dwell restarts per select and saturates so a stalled nibble keeps its count.
        if (capture || advance)
            dwell_d = '0;
        else if ((state_q == ST_SCAN) && (dwell_q != DWELL_LAST))
            dwell_d = dwell_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            w_q     <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            dwell_q <= dwell_d;
        end
    end

    sel_counter_mod8 u_sel (
        .clk      (clk),
        .rst      (rst),
        .load     (capture),
        .load_val (FIRST_SEL),
        .en       (advance && !last_sel),
        .down     (SCAN_DOWN),
        .cnt      (s),
        .tc       (last_sel)
    );

    assign w     = w_q;
    assign valid = (state_q == ST_SCAN);
    assign busy  = (state_q == ST_SCAN) || (state_q == ST_DONE);
    assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_nibble_scanner.sv
// Bench for nibble_scanner: DWELL=1 and DWELL=4 instances share stimulus and
// are checked every cycle against a scan-position model, plus directed literals.
module tb_nibble_scanner;

    logic        clk = 1'b0;
    logic        rst, start, ready;
    logic [31:0] din;

    logic [31:0] w1, w4;
    logic [2:0]  s1, s4;
    logic        v1, v4, b1, b4, d1, d4;

    int compared   = 0;
    int mismatched = 0;

`ifdef NIBBLE_SCAN_DOWN_EN
    localparam int FIRST = 7;
    localparam int STEP  = -1;
`else
    localparam int FIRST = 0;
    localparam int STEP  = 1;
`endif

    always #5 clk = ~clk;

    nibble_scanner #(.DWELL(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .din(din), .ready(ready),
        .w(w1), .s(s1), .valid(v1), .busy(b1), .done(d1)
    );

    nibble_scanner #(.DWELL(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .din(din), .ready(ready),
        .w(w4), .s(s4), .valid(v4), .busy(b4), .done(d4)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] selAt(input int i);
        int v;
        v = FIRST + STEP * i;
        return v[2:0];
    endfunction

    function automatic int dwellOf(input int u);
        return (u == 0) ? 1 : 4;
    endfunction

    // Model: phase 0=idle 1=scan 2=done; pos counts nibbles already consumed,
    // shown counts whole cycles the current nibble has been on display.
    int          m_phase[2];
    logic [31:0] m_word[2];
    int          m_pos[2];
    int          m_shown[2];
    int          m_sel[2];

    always @(posedge clk or posedge rst) begin
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                m_phase[u] <= 0;
                m_word[u]  <= 32'h0;
                m_pos[u]   <= 0;
                m_shown[u] <= 0;
                m_sel[u]   <= 0;
            end else begin
                case (m_phase[u])
                    0: if (start) begin
                        m_phase[u] <= 1;
                        m_word[u]  <= din;
                        m_pos[u]   <= 0;
                        m_shown[u] <= 0;
                        m_sel[u]   <= FIRST;
                    end
                    1: if (ready && (m_shown[u] + 1 >= dwellOf(u))) begin
                        if (m_pos[u] == 7) begin
                            m_phase[u] <= 2;
                        end else begin
                            m_pos[u]   <= m_pos[u] + 1;
                            m_sel[u]   <= FIRST + STEP * (m_pos[u] + 1);
                            m_shown[u] <= 0;
                        end
                    end else begin
                        m_shown[u] <= m_shown[u] + 1;
                    end
                    default: m_phase[u] <= 0;
                endcase
            end
        end
    end

    task automatic compareUnit(input int u, input logic [31:0] w, input logic [2:0] s,
                               input logic v, input logic b, input logic d);
        string tag;
        tag = (u == 0) ? "dwell1" : "dwell4";
        checkOutput({tag, ".valid"}, {31'b0, v}, {31'b0, m_phase[u] == 1});
        checkOutput({tag, ".busy"},  {31'b0, b}, {31'b0, m_phase[u] != 0});
        checkOutput({tag, ".done"},  {31'b0, d}, {31'b0, m_phase[u] == 2});
        checkOutput({tag, ".s"},     {29'b0, s}, m_sel[u]);
        checkOutput({tag, ".w"},     w,          m_word[u]);
    endtask

    always @(negedge clk) begin
        compareUnit(0, w1, s1, v1, b1, d1);
        compareUnit(1, w4, s4, v4, b4, d4);
    end

    task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] d);
        start = st;
        ready = rd;
        din   = d;
    endtask

    task automatic stepCycle(inout int v4cnt);
        @(posedge clk);
        #1;
        if (v4) v4cnt++;
    endtask

    initial begin
        int v4cnt;
        v4cnt = 0;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        #12;
        checkOutput("reset_s",     {29'b0, s1}, 32'h0);
        checkOutput("reset_w",     w1,          32'h0);
        checkOutput("reset_valid", {31'b0, v1}, 32'h0);
        checkOutput("reset_busy",  {31'b0, b1}, 32'h0);
        checkOutput("reset_done",  {31'b0, d1}, 32'h0);

        // Basic scan, with start presented on the first edge after reset release.
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 32'h8765_4321);
        stepCycle(v4cnt);
        applyStimulus(1'b0, 1'b1, 32'h0);
        checkOutput("scan_first_s", {29'b0, s1}, {29'b0, selAt(0)});
        checkOutput("scan_w",       w1,          32'h8765_4321);
        checkOutput("scan_valid",   {31'b0, v1}, 32'h1);
        for (int i = 1; i < 8; i++) begin
            stepCycle(v4cnt);
            checkOutput("scan_s", {29'b0, s1}, {29'b0, selAt(i)});
            if (i == 3) checkOutput("dwell_hold_s", {29'b0, s4}, {29'b0, selAt(0)});
            if (i == 4) checkOutput("dwell_step_s", {29'b0, s4}, {29'b0, selAt(1)});
        end
        stepCycle(v4cnt);
        checkOutput("scan_done_pulse", {31'b0, d1}, 32'h1);
        checkOutput("scan_done_valid", {31'b0, v1}, 32'h0);
        checkOutput("scan_done_busy",  {31'b0, b1}, 32'h1);
        checkOutput("scan_done_s",     {29'b0, s1}, {29'b0, selAt(7)});
        checkOutput("scan_done_w",     w1,          32'h8765_4321);
        stepCycle(v4cnt);
        checkOutput("scan_idle_done", {31'b0, d1}, 32'h0);
        checkOutput("scan_idle_busy", {31'b0, b1}, 32'h0);

        for (int i = 0; i < 60 && !d4; i++) stepCycle(v4cnt);
        checkOutput("dwell_done_seen",   {31'b0, d4}, 32'h1);
        checkOutput("dwell_scan_cycles", v4cnt,       32'd32);
        stepCycle(v4cnt);

        // Backpressure at index 2, with a start pulse that must be ignored.
        applyStimulus(1'b1, 1'b1, 32'hA5C3_0F96);
        stepCycle(v4cnt);
        applyStimulus(1'b0, 1'b1, 32'h0);
        stepCycle(v4cnt);
        stepCycle(v4cnt);
        checkOutput("bp_at_2", {29'b0, s1}, {29'b0, selAt(2)});
        applyStimulus(1'b1, 1'b0, 32'hFFFF_FFFF);
        for (int i = 0; i < 5; i++) begin
            stepCycle(v4cnt);
            checkOutput("bp_hold_s",     {29'b0, s1}, {29'b0, selAt(2)});
            checkOutput("bp_hold_valid", {31'b0, v1}, 32'h1);
            checkOutput("bp_hold_w",     w1,          32'hA5C3_0F96);
        end
        applyStimulus(1'b0, 1'b1, 32'h0);
        stepCycle(v4cnt);
        checkOutput("bp_release_s", {29'b0, s1}, {29'b0, selAt(3)});
        for (int i = 0; i < 20 && !d1; i++) stepCycle(v4cnt);
        checkOutput("bp_done_seen", {31'b0, d1}, 32'h1);

        // Start held through DONE: ignored in DONE, captured in the following IDLE cycle.
        applyStimulus(1'b1, 1'b1, 32'h1357_9BDF);
        stepCycle(v4cnt);
        checkOutput("b2b_idle_busy", {31'b0, b1}, 32'h0);
        checkOutput("b2b_idle_w",    w1,          32'hA5C3_0F96);
        stepCycle(v4cnt);
        applyStimulus(1'b0, 1'b1, 32'h0);
        checkOutput("b2b_capture_w",     w1,          32'h1357_9BDF);
        checkOutput("b2b_capture_valid", {31'b0, v1}, 32'h1);
        checkOutput("b2b_capture_s",     {29'b0, s1}, {29'b0, selAt(0)});

        // Asynchronous reset mid-scan at index 3.
        for (int i = 0; i < 3; i++) stepCycle(v4cnt);
        checkOutput("rst_pre_s", {29'b0, s1}, {29'b0, selAt(3)});
        rst = 1'b1;
        #1;
        checkOutput("rst_async_s",     {29'b0, s1}, 32'h0);
        checkOutput("rst_async_w",     w1,          32'h0);
        checkOutput("rst_async_valid", {31'b0, v1}, 32'h0);
        checkOutput("rst_async_busy",  {31'b0, b1}, 32'h0);
        checkOutput("rst_async_done",  {31'b0, d1}, 32'h0);
        checkOutput("rst_async_busy4", {31'b0, b4}, 32'h0);
        stepCycle(v4cnt);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 3; i++) begin
            stepCycle(v4cnt);
            checkOutput("rst_no_done", {31'b0, d1}, 32'h0);
        end
        applyStimulus(1'b1, 1'b1, 32'hCAFE_BABE);
        stepCycle(v4cnt);
        applyStimulus(1'b0, 1'b1, 32'h0);
        checkOutput("rst_restart_w",     w1,          32'hCAFE_BABE);
        checkOutput("rst_restart_valid", {31'b0, v1}, 32'h1);
        for (int i = 0; i < 20 && !d1; i++) stepCycle(v4cnt);
        checkOutput("rst_restart_done", {31'b0, d1}, 32'h1);
        for (int i = 0; i < 60 && b4; i++) stepCycle(v4cnt);
        checkOutput("final_idle4", {31'b0, b4}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
